relu_maxpool2d_stream: RTL and testbench
========================================

// Module: relu_maxpool2d_stream
// PURPOSE
//  Streaming ReLU + 2x2/stride-2 max-pool stage, directly downstream of one conv2d_3 featuremap filter.
//  Consumes the filter's fp32 result stream (data_out/valid_out, raster order, WIDTH x HEIGHT per frame).
//  Emits one pooled fp32 value per 2x2 window, (WIDTH/2)x(HEIGHT/2) per frame, to the next layer's FIFO.
//  ReLU is applied before the max, so every candidate is >= +0 and is compared as an unsigned integer.
// PARAMETERS
//  DATA_WIDTH  32  word width, IEEE-754 single precision
//  WIDTH       56  input columns per row; must be even
//  HEIGHT      56  input rows per frame; must be even
// PORTS
//  clk        in   1           clock
//  rst        in   1           synchronous reset, active-high
//  data_in    in   DATA_WIDTH  conv+bias result pixel
//  valid_in   in   1           data_in valid this cycle (driven by filter valid_out)
//  data_out   out  DATA_WIDTH  pooled, ReLU'd pixel
//  valid_out  out  1           data_out valid, single-cycle pulse per pooled pixel
//  frame_done out  1           pulses together with the last valid_out of a frame
// BEHAVIOUR
//  - One clock (clk); reset is synchronous and active-high (rst). All state changes on posedge clk.
//  - Reset: data_out=0, valid_out=0, frame_done=0, col=0, row=0, pair reg=0. Line buffer is not cleared.
//    Its contents are always rewritten on an even row before they are read.
//  - No backpressure. Counters advance only on cycles with valid_in=1. Gaps of any length are allowed.
//    State holds during gaps; valid_out=0 on every cycle without a completing input.
//  - ReLU: r = data_in[DATA_WIDTH-1] ? 0 : data_in. -0.0 maps to 0. Positive NaN/Inf pass through.
//  - max(a,b) = (a >= b unsigned) ? a : b. This is exact for non-negative IEEE values.
//  - Counters: col 0..WIDTH-1, row 0..HEIGHT-1.
//    col wraps to 0 and row increments at col=WIDTH-1.
//    row wraps to 0 at the end of the frame.
//  - Even col: pair <= r.
//  - Odd col, even row: linebuf[col>>1] <= max(pair, r). No output.
//  - Odd col, odd row: data_out <= max(max(pair, r), linebuf[col>>1]); valid_out <= 1.
//    Latency is 1 cycle from the accepting edge of the window's bottom-right pixel.
//  - frame_done <= 1 on the same edge as valid_out when row=HEIGHT-1 and col=WIDTH-1. Otherwise 0.
//  - Line buffer: WIDTH/2 entries x DATA_WIDTH, one write port and one read port, combinational or
//    same-cycle read. No read-after-write hazard: write rows and read rows alternate.
//  - Back-to-back frames: pixel (0,0) of frame N+1 may arrive the cycle after the last pixel of frame N.
//    No bubble is required.
//  - rst mid-frame: the partial window and partial frame are discarded. The next valid_in is pixel (0,0).
//    No output is produced from pre-reset data.
//  - Output rate is at most 1 per 2 accepted inputs, so no output buffering is needed.
// TESTING (WIDTH=4, HEIGHT=4 unless noted)
//  1 Reset: hold rst 3 cycles with valid_in=1 -> valid_out=0, data_out=0, frame_done=0 throughout.
//  2 Frame values: 16 consecutive pixels, window(0,0)={1.0,2.0,0.5,-3.0} = {3F800000,40000000,3F000000,C0400000}.
//    Remaining windows are all 3F000000.
//    -> out[0]=40000000, out[1..3]=3F000000; valid_out pulses on the cycles after inputs 6,8,14,16;
//    frame_done on the 4th pulse only.
//  3 All-negative window {C0400000,BF800000,80000000,C0000000} -> data_out=00000000, valid_out=1.
//  4 Same stream as 2 with valid_in low for 1..5 random cycles between pixels -> identical outputs.
//    Each output comes exactly 1 cycle after its completing pixel.
//  5 Two frames back-to-back with no gap -> 8 outputs, frame_done twice, second frame uncorrupted by the first.
//  6 rst for 1 cycle after 7 pixels, then a full clean frame -> exactly 4 outputs, all from the clean frame.
//    Separately, WIDTH=HEIGHT=56 random fp32 stream -> matches a software relu+maxpool model bit-exactly.

Source files
------------

// File: rtl/relu_maxpool2d_stream.sv
// ReLU + 2x2/stride-2 max-pool on a raster fp32 stream; one pooled word 1 cycle after each window's last pixel.
// No backpressure: state advances only on valid_in, gaps hold state, output rate is at most 1 per 2 inputs.
module relu_maxpool2d_stream #(
  parameter int DATA_WIDTH = 32,
  parameter int WIDTH      = 56,
  parameter int HEIGHT     = 56
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  frame_done
);

  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(HEIGHT);
  localparam int LB = WIDTH / 2;
  localparam int LW = (LB > 1) ? $clog2(LB) : 1;

  logic [CW-1:0]         col;
  logic [RW-1:0]         row;
  logic [DATA_WIDTH-1:0] pair;
  logic [DATA_WIDTH-1:0] linebuf [LB];

  logic [LW-1:0]         lb_idx;
  logic [DATA_WIDTH-1:0] relu_val;
  logic [DATA_WIDTH-1:0] pair_max;
  logic [DATA_WIDTH-1:0] lb_rd;
  logic [DATA_WIDTH-1:0] win_max;
  logic                  last_col;
  logic                  last_row;

  // Sign bit set means negative (including -0.0); non-negative IEEE values order as unsigned ints.
  assign relu_val = data_in[DATA_WIDTH-1] ? '0 : data_in;
  assign lb_idx   = LW'(col >> 1);
  assign lb_rd    = linebuf[lb_idx];
  assign pair_max = (pair >= relu_val) ? pair : relu_val;
  assign win_max  = (pair_max >= lb_rd) ? pair_max : lb_rd;
  assign last_col = (col == CW'(WIDTH - 1));
  assign last_row = (row == RW'(HEIGHT - 1));

  // Even rows fill the line buffer, odd rows consume it, so no clear is needed on reset.
  always_ff @(posedge clk) begin
    if (!rst && valid_in && col[0] && !row[0]) begin
      linebuf[lb_idx] <= pair_max;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_out   <= '0;
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
      col        <= '0;
      row        <= '0;
      pair       <= '0;
    end else begin
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
      if (valid_in) begin
        if (!col[0]) begin
          pair <= relu_val;
        end else if (row[0]) begin
          data_out   <= win_max;
          valid_out  <= 1'b1;
          frame_done <= last_row && last_col;
        end
        if (last_col) begin
          col <= '0;
          row <= last_row ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_relu_maxpool2d_stream.sv
// Scoreboard bench: small 4x4 instance for directed cases, 56x56 instance for a random frame.
module tb_relu_maxpool2d_stream;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int BW = 56;
  localparam int BH = 56;

  typedef struct {
    logic [31:0] d;
    logic        fd;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data_in;
  logic        valid_in;
  logic [31:0] data_out;
  logic        valid_out;
  logic        frame_done;

  logic        rst56;
  logic [31:0] data_in56;
  logic        valid_in56;
  logic [31:0] data_out56;
  logic        valid_out56;
  logic        frame_done56;

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;
  int out_cnt = 0;
  int fd_cnt  = 0;
  exp_t q[$];
  exp_t q56[$];
  logic [31:0] frm   [W*H];
  logic [31:0] frm56 [BW*BH];

  relu_maxpool2d_stream #(.DATA_WIDTH(32), .WIDTH(W), .HEIGHT(H)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in),
    .data_out(data_out), .valid_out(valid_out), .frame_done(frame_done)
  );

  relu_maxpool2d_stream #(.DATA_WIDTH(32), .WIDTH(BW), .HEIGHT(BH)) dut56 (
    .clk(clk), .rst(rst56), .data_in(data_in56), .valid_in(valid_in56),
    .data_out(data_out56), .valid_out(valid_out56), .frame_done(frame_done56)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] relu(input logic [31:0] v);
    return v[31] ? 32'h0 : v;
  endfunction

  function automatic logic [31:0] wmax(input logic [31:0] a, b, c, d);
    logic [31:0] m;
    m = relu(a);
    if (relu(b) > m) m = relu(b);
    if (relu(c) > m) m = relu(c);
    if (relu(d) > m) m = relu(d);
    return m;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (valid_out === 1'b1) begin
      out_cnt++;
      if (frame_done === 1'b1) fd_cnt++;
      if (q.size() == 0) chk("spurious_out", 1, 0);
      else begin
        e = q.pop_front();
        chk("data", data_out, e.d);
        chk("frame_done", frame_done, e.fd);
        chk("latency", cyc, e.cyc);
      end
    end else if (frame_done !== 1'b0 && rst === 1'b0) begin
      chk("fd_without_vld", frame_done, 0);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (valid_out56 === 1'b1) begin
      if (q56.size() == 0) chk("spurious_out56", 1, 0);
      else begin
        e = q56.pop_front();
        chk("data56", data_out56, e.d);
        chk("frame_done56", frame_done56, e.fd);
        chk("latency56", cyc, e.cyc);
      end
    end
  end

  // Drives the first npix pixels of frm; windows completed by a driven pixel are queued.
  task automatic drive_frame(input int npix, input int gmin, input int gmax);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (r * W + c < npix) begin
          if (gmax > 0) begin
            repeat ($urandom_range(gmax, gmin)) begin
              @(negedge clk);
              valid_in = 1'b0;
              data_in  = $urandom;
            end
          end
          @(negedge clk);
          data_in  = frm[r*W+c];
          valid_in = 1'b1;
          if ((r % 2 == 1) && (c % 2 == 1))
            q.push_back('{wmax(frm[(r-1)*W+c-1], frm[(r-1)*W+c], frm[r*W+c-1], frm[r*W+c]),
                          (r == H-1 && c == W-1), cyc + 1});
        end
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      valid_in = 1'b0;
    end
  endtask

  task automatic base_frame();
    for (int i = 0; i < W*H; i++) frm[i] = 32'h3F000000;
    frm[0] = 32'h3F800000;
    frm[1] = 32'h40000000;
    frm[W] = 32'h3F000000;
    frm[W+1] = 32'hC0400000;
  endtask

  initial begin
    #1_000_000;
    nerr++;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $fatal(1, "watchdog");
  end

  initial begin
    int base_out;
    int base_fd;
    rst = 1'b1; valid_in = 1'b1; data_in = 32'h3F800000;
    rst56 = 1'b1; valid_in56 = 1'b0; data_in56 = '0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_valid_out", valid_out, 0);
      chk("rst_data_out", data_out, 0);
      chk("rst_frame_done", frame_done, 0);
    end
    rst = 1'b0; valid_in = 1'b0; rst56 = 1'b0;

    // Consecutive frame, then same frame with gaps.
    base_frame();
    base_out = out_cnt; base_fd = fd_cnt;
    drive_frame(W*H, 0, 0);
    idle(4);
    chk("t2_count", out_cnt - base_out, 4);
    chk("t2_fd_count", fd_cnt - base_fd, 1);
    chk("t2_q_empty", q.size(), 0);
    drive_frame(W*H, 1, 5);
    idle(4);
    chk("t4_q_empty", q.size(), 0);

    // All-negative first window, including -0.0.
    for (int i = 0; i < W*H; i++) frm[i] = $urandom & 32'h7FFFFFFF;
    frm[0] = 32'hC0400000; frm[1] = 32'hBF800000;
    frm[W] = 32'h80000000; frm[W+1] = 32'hC0000000;
    drive_frame(W*H, 0, 0);
    idle(4);
    chk("t3_q_empty", q.size(), 0);

    // Back-to-back frames with no bubble.
    base_fd = fd_cnt; base_out = out_cnt;
    for (int i = 0; i < W*H; i++) frm[i] = $urandom;
    drive_frame(W*H, 0, 0);
    for (int i = 0; i < W*H; i++) frm[i] = $urandom;
    drive_frame(W*H, 0, 0);
    idle(4);
    chk("t5_out_count", out_cnt - base_out, 8);
    chk("t5_fd_count", fd_cnt - base_fd, 2);
    chk("t5_q_empty", q.size(), 0);

    // Reset mid-frame after 7 pixels, then a clean frame.
    for (int i = 0; i < W*H; i++) frm[i] = 32'h47000000 + i;
    drive_frame(7, 0, 0);
    @(negedge clk);
    valid_in = 1'b1; data_in = 32'h7F000000; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; valid_in = 1'b0;
    chk("t6_q_after_rst", q.size(), 0);
    base_out = out_cnt;
    for (int i = 0; i < W*H; i++) frm[i] = $urandom & 32'h3FFFFFFF;
    drive_frame(W*H, 0, 0);
    idle(4);
    chk("t6_out_count", out_cnt - base_out, 4);
    chk("t6_q_empty", q.size(), 0);

    // Full-size random frame on the 56x56 instance.
    for (int i = 0; i < BW*BH; i++) frm56[i] = $urandom;
    frm56[1] = 32'h80000000;
    frm56[2] = 32'h7FC00000;
    for (int r = 0; r < BH; r++) begin
      for (int c = 0; c < BW; c++) begin
        if ($urandom_range(3, 0) == 0) begin
          @(negedge clk);
          valid_in56 = 1'b0;
          data_in56  = $urandom;
        end
        @(negedge clk);
        data_in56  = frm56[r*BW+c];
        valid_in56 = 1'b1;
        if ((r % 2 == 1) && (c % 2 == 1))
          q56.push_back('{wmax(frm56[(r-1)*BW+c-1], frm56[(r-1)*BW+c], frm56[r*BW+c-1], frm56[r*BW+c]),
                          (r == BH-1 && c == BW-1), cyc + 1});
      end
    end
    @(negedge clk);
    valid_in56 = 1'b0;
    repeat (4) @(negedge clk);
    chk("big_q_empty", q56.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
